// File: rtl/uart_wb_cfg_seq.sv
// Wishbone master that programs a 16550-style UART register file:
// LCR(DLAB=1), DLL, DLM, LCR(DLAB=0), FCR, IER, MCR, then reads LCR back.
module uart_wb_cfg_seq #(
    parameter int         ACK_TIMEOUT = 16,
    parameter logic [3:0] SEL_VALUE   = 4'b0001
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [15:0] divisor,
    input  logic [6:0]  lcr_fmt,
    input  logic [7:0]  fcr_val,
    input  logic [3:0]  ier_val,
    input  logic [4:0]  mcr_val,
    output logic [4:0]  wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [2:0]  err_step
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_TMO  = 2'b01;
    localparam logic [1:0] E_RDBK = 2'b10;
    localparam logic [1:0] E_DIV0 = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [15:0] div_q, div_d;
    logic [6:0]  lcr_q, lcr_d;
    logic [7:0]  fcr_q, fcr_d;
    logic [3:0]  ier_q, ier_d;
    logic [4:0]  mcr_q, mcr_d;
    logic [4:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic [2:0]  estep_q, estep_d;

    // Bus word {adr, we, dat} for one step of the programming sequence.
    function automatic logic [13:0] step_word(
        input logic [2:0]  s,
        input logic [15:0] dv,
        input logic [6:0]  lf,
        input logic [7:0]  fc,
        input logic [3:0]  ie,
        input logic [4:0]  mc
    );
        case (s)
            3'd0:    return {5'd3, 1'b1, 1'b1, lf};
            3'd1:    return {5'd0, 1'b1, dv[7:0]};
            3'd2:    return {5'd1, 1'b1, dv[15:8]};
            3'd3:    return {5'd3, 1'b1, 1'b0, lf};
            3'd4:    return {5'd2, 1'b1, fc};
            3'd5:    return {5'd1, 1'b1, 4'b0000, ie};
            3'd6:    return {5'd4, 1'b1, 3'b000, mc};
            default: return {5'd3, 1'b0, 8'h00};
        endcase
    endfunction

    // Next-state logic for the sequencer FSM, bus registers and status.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tmo_d   = tmo_q;
        div_d   = div_q;
        lcr_d   = lcr_q;
        fcr_d   = fcr_q;
        ier_d   = ier_q;
        mcr_d   = mcr_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        code_d  = code_q;
        estep_d = estep_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d   = divisor;
                    lcr_d   = lcr_fmt;
                    fcr_d   = fcr_val;
                    ier_d   = ier_val;
                    mcr_d   = mcr_val;
                    err_d   = 1'b0;
                    code_d  = E_NONE;
                    estep_d = 3'd0;
                    busy_d  = 1'b1;
                    step_d  = 3'd0;
                    tmo_d   = 8'd0;
                    if (divisor == 16'd0) begin
                        err_d   = 1'b1;
                        code_d  = E_DIV0;
                        state_d = S_FIN;
                    end else begin
                        {adr_d, we_d, dat_d} = step_word(3'd0, divisor, lcr_fmt,
                                                         fcr_val, ier_val, mcr_val);
                        cyc_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (wb_ack_i || tmo_q == TMO_LAST) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    adr_d = 5'd0;
                    dat_d = 8'd0;
                end
                if (wb_ack_i) begin
                    if (step_q == 3'd7) begin
                        state_d = S_FIN;
                        if (wb_dat_i != {1'b0, lcr_q}) begin
                            err_d   = 1'b1;
                            code_d  = E_RDBK;
                            estep_d = 3'd7;
                        end
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    code_d  = E_TMO;
                    estep_d = step_q;
                    state_d = S_FIN;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_GAP: begin
                step_d = step_q + 3'd1;
                tmo_d  = 8'd0;
                {adr_d, we_d, dat_d} = step_word(step_q + 3'd1, div_q, lcr_q,
                                                 fcr_q, ier_q, mcr_q);
                cyc_d   = 1'b1;
                state_d = S_REQ;
            end
            default: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            step_q  <= 3'd0;
            tmo_q   <= 8'd0;
            div_q   <= 16'd0;
            lcr_q   <= 7'd0;
            fcr_q   <= 8'd0;
            ier_q   <= 4'd0;
            mcr_q   <= 5'd0;
            adr_q   <= 5'd0;
            dat_q   <= 8'd0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            estep_q <= 3'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tmo_q   <= tmo_d;
            div_q   <= div_d;
            lcr_q   <= lcr_d;
            fcr_q   <= fcr_d;
            ier_q   <= ier_d;
            mcr_q   <= mcr_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            estep_q <= estep_d;
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_sel_o = cyc_q ? SEL_VALUE : 4'b0000;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign err_step = estep_q;

endmodule

// File: tb/tb_uart_wb_cfg_seq.sv
// Bench for uart_wb_cfg_seq: behavioural UART slave plus a scoreboard of
// expected bus accesses, driven from a single process.
module tb_uart_wb_cfg_seq;
    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        start = 1'b0;
    logic [15:0] divisor = 16'd0;
    logic [6:0]  lcr_fmt = 7'd0;
    logic [7:0]  fcr_val = 8'd0;
    logic [3:0]  ier_val = 4'd0;
    logic [4:0]  mcr_val = 5'd0;
    logic [4:0]  wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [2:0]  err_step;

    uart_wb_cfg_seq dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .start(start), .divisor(divisor),
        .lcr_fmt(lcr_fmt), .fcr_val(fcr_val), .ier_val(ier_val), .mcr_val(mcr_val),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .err_step(err_step)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [13:0] sb[$];
    logic [7:0]  rb_val = 8'h03;
    int          ack_n = 2;
    int          no_ack_idx = 99;
    logic        idle_ack = 1'b0;
    int          acc_idx = 0;
    int          stb_cnt = 0;
    int          low_cnt = 0;
    int          last_run = 0;
    int          stb_total = 0;

    assign wb_dat_i = rb_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: slave response and bus monitor, evaluated on the falling edge.
    task automatic tick();
        logic [13:0] w;
        @(negedge clk);
        if (!busy || wb_rst_i) acc_idx = 0;
        if (wb_stb_o) begin
            stb_cnt++;
            stb_total++;
            if (stb_cnt == 1 && acc_idx > 0) chk("gap", low_cnt, 1);
            low_cnt = 0;
            chk("sel", {28'd0, wb_sel_o}, 32'd1);
            chk("cyc", {31'd0, wb_cyc_o}, 32'd1);
            wb_ack_i = (stb_cnt == ack_n) && (acc_idx != no_ack_idx);
        end else begin
            if (stb_cnt != 0) last_run = stb_cnt;
            stb_cnt = 0;
            if (busy) low_cnt++;
            wb_ack_i = idle_ack;
        end
        if (wb_stb_o && wb_ack_i) begin
            chk("sb_avail", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                w = sb.pop_front();
                chk($sformatf("acc%0d", acc_idx), {18'd0, wb_adr_o, wb_we_o, wb_dat_o}, {18'd0, w});
            end
            acc_idx++;
        end
    endtask

    task automatic set_cfg(input logic [15:0] dv, input logic [6:0] lf, input logic [7:0] fc,
                           input logic [3:0] ie, input logic [4:0] mc, input int nsteps);
        logic [4:0] adr[8];
        logic [7:0] dat[8];
        divisor = dv; lcr_fmt = lf; fcr_val = fc; ier_val = ie; mcr_val = mc;
        adr = '{5'd3, 5'd0, 5'd1, 5'd3, 5'd2, 5'd1, 5'd4, 5'd3};
        dat = '{{1'b1, lf}, dv[7:0], dv[15:8], {1'b0, lf}, fc, {4'd0, ie}, {3'd0, mc}, 8'h00};
        sb.delete();
        for (int i = 0; i < nsteps; i++) sb.push_back({adr[i], (i != 7), dat[i]});
    endtask

    // Pulse start and wait (bounded) for done; optionally re-pulse start while busy.
    task automatic run(input bit extra, output int n_cyc, output int n_busy);
        bit got;
        got = 0; n_cyc = 0; n_busy = 0;
        start = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            start = extra && (i % 5 == 3);
            n_cyc++;
            if (busy) n_busy++;
            if (done) got = 1;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, got}, 32'd1);
        tick();
        chk("done_single", {31'd0, done}, 32'd0);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic chk_status(input string tag, input logic e, input logic [1:0] c, input logic [2:0] s);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
        chk({tag, "_code"}, {30'd0, err_code}, {30'd0, c});
        chk({tag, "_step"}, {29'd0, err_step}, {29'd0, s});
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
                  busy, done, err, err_code, err_step}, 32'd0);
    endtask

    int nc, nb, s0;
    bit hit;

    initial begin
        // reset state
        repeat (3) tick();
        chk_all_zero("reset_outs");
        wb_rst_i = 1'b0;
        tick();

        // nominal
        set_cfg(16'h0145, 7'h03, 8'hC7, 4'h1, 5'h03, 8);
        rb_val = 8'h03;
        run(0, nc, nb);
        chk("nom_cycles", nc, 25);
        chk("nom_busy", nb, 24);
        chk_status("nom", 1'b0, 2'b00, 3'd0);

        // ack timeout on step 2 (DLM); DLL must still have been written
        set_cfg(16'h0145, 7'h03, 8'hC7, 4'h1, 5'h03, 2);
        no_ack_idx = 2;
        run(0, nc, nb);
        no_ack_idx = 99;
        chk("tmo_stb_len", last_run, 16);
        chk_status("tmo", 1'b1, 2'b01, 3'd2);

        // readback mismatch: slave reports DLAB still set
        set_cfg(16'h0145, 7'h03, 8'hC7, 4'h1, 5'h03, 8);
        rb_val = 8'h83;
        run(0, nc, nb);
        rb_val = 8'h03;
        chk_status("rdbk", 1'b1, 2'b10, 3'd7);

        // zero divisor: no bus traffic at all
        set_cfg(16'h0000, 7'h1B, 8'h07, 4'hF, 5'h1F, 0);
        s0 = stb_total;
        run(0, nc, nb);
        chk("div0_cycles", nc, 2);
        chk("div0_nostb", stb_total - s0, 0);
        chk_status("div0", 1'b1, 2'b11, 3'd0);

        // ack pulses while idle are ignored
        idle_ack = 1'b1;
        s0 = stb_total;
        repeat (5) tick();
        idle_ack = 1'b0;
        chk("idle_nostb", stb_total - s0, 0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk_status("idle", 1'b1, 2'b11, 3'd0);

        // start re-pulsed while busy; different config, slave acks on 1st stb cycle
        set_cfg(16'hA503, 7'h3F, 8'h81, 4'hA, 5'h15, 8);
        rb_val = 8'h3F;
        ack_n = 1;
        run(1, nc, nb);
        chk("fast_busy", nb, 16);
        chk_status("fast", 1'b0, 2'b00, 3'd0);
        ack_n = 2;

        // reset in the middle of step 4
        set_cfg(16'h0145, 7'h03, 8'hC7, 4'h1, 5'h03, 4);
        rb_val = 8'h03;
        start = 1'b1;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick();
            start = 1'b0;
            if (acc_idx == 4 && wb_stb_o) hit = 1;
        end
        chk("rst_reach_step4", {31'd0, hit}, 32'd1);
        chk("rst_sb", sb.size(), 0);
        wb_rst_i = 1'b1;
        tick();
        chk_all_zero("rst_mid_outs");
        wb_rst_i = 1'b0;
        tick();
        chk("rst_no_done", {31'd0, done}, 32'd0);

        // fresh sequence after reset starts from step 0
        set_cfg(16'h0145, 7'h03, 8'hC7, 4'h1, 5'h03, 8);
        run(0, nc, nb);
        chk("post_rst_busy", nb, 24);
        chk_status("post_rst", 1'b0, 2'b00, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
